sky130_fd_io__xres_seq_ctrl: RTL

// Sequencer/conditioner for the top_xres4v2 XRES pad cell. Brings the pad up in a

---
 rtl/sky130_fd_io__xres_seq_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sky130_fd_io__xres_seq_ctrl.sv
// XRES pad sequencer: power-up ordering, XRES_H_N debounce, stretched system reset.
// Latency: 2-cycle input synchroniser, registered outputs one edge after each state change.
// Backpressure: none; optional glitch counter under SKY130_FD_IO_XRES_SEQ_GLITCH_CNT_EN.
module sky130_fd_io__xres_seq_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int FILT_CYC    = 8,
    parameter int STRETCH_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic       PWR_GOOD,
    input  logic       CFG_VCCHIB_MODE,
    input  logic       CFG_USE_FILT,
    input  logic       XRES_H_N_IN,
    output logic       ENABLE_VDDIO,
    output logic       ENABLE_H,
    output logic       EN_VDDIO_SIG_H,
    output logic       INP_SEL_H,
    output logic       DISABLE_PULLUP_H,
    output logic       FILT_IN_H,
    output logic       SYS_RST_N,
    output logic       READY,
    output logic       GLITCH,
    output logic [7:0] GLITCH_CNT
);

    typedef enum logic [2:0] {
        S_OFF, S_PREP, S_SETTLE, S_ACTIVE, S_FILTER, S_ASSERT, S_STRETCH
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FILT_LD    = CNT_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
    logic             xs_meta, xs;
    logic             vcchib_q, vcchib_nxt;
    logic             use_filt_q, use_filt_nxt;
    logic             glitch_nxt;
    logic             en_vddio_nxt, en_h_nxt, en_sig_nxt, inp_sel_nxt;
    logic             filt_in_nxt, sys_rst_n_nxt, ready_nxt;

    // Pad idles high, so the synchroniser resets to "not in reset".
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            xs_meta <= 1'b1;
            xs      <= 1'b1;
        end else begin
            xs_meta <= XRES_H_N_IN;
            xs      <= xs_meta;
        end
    end

    assign cnt_dec = (cnt != '0) ? cnt - CNT_W'(1) : cnt;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        vcchib_nxt   = vcchib_q;
        use_filt_nxt = use_filt_q;
        glitch_nxt   = 1'b0;
        if (!PWR_GOOD) begin
            state_nxt = S_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_OFF: state_nxt = S_PREP;
                S_PREP: begin
                    vcchib_nxt   = CFG_VCCHIB_MODE;
                    use_filt_nxt = CFG_USE_FILT;
                    state_nxt    = S_SETTLE;
                    cnt_nxt      = SETTLE_LD;
                end
                S_SETTLE: begin
                    if (cnt == '0) state_nxt = S_ACTIVE;
                    else           cnt_nxt   = cnt_dec;
                end
                S_ACTIVE: begin
                    if (!xs) begin
                        state_nxt = S_FILTER;
                        cnt_nxt   = FILT_LD;
                    end
                end
                S_FILTER: begin
                    if (xs) begin
                        state_nxt  = S_ACTIVE;
                        glitch_nxt = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt = S_ASSERT;
                    end else begin
                        cnt_nxt = cnt_dec;
                    end
                end
                S_ASSERT: begin
                    if (xs) begin
                        state_nxt = S_STRETCH;
                        cnt_nxt   = STRETCH_LD;
                    end
                end
                S_STRETCH: begin
                    // A new request during the stretch restarts the whole assert/stretch.
                    if (!xs)              state_nxt = S_ASSERT;
                    else if (cnt == '0)   state_nxt = S_ACTIVE;
                    else                  cnt_nxt   = cnt_dec;
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        en_vddio_nxt  = 1'b0;
        en_h_nxt      = 1'b0;
        en_sig_nxt    = 1'b1;
        inp_sel_nxt   = 1'b0;
        filt_in_nxt   = 1'b1;
        sys_rst_n_nxt = 1'b0;
        ready_nxt     = 1'b0;
        case (state_nxt)
            S_OFF: ;
            S_PREP: en_vddio_nxt = 1'b1;
            S_SETTLE: begin
                en_vddio_nxt = 1'b1;
                en_h_nxt     = 1'b1;
                en_sig_nxt   = !vcchib_nxt;
            end
            default: begin
                en_vddio_nxt  = 1'b1;
                en_h_nxt      = 1'b1;
                en_sig_nxt    = !vcchib_nxt;
                inp_sel_nxt   = use_filt_nxt;
                sys_rst_n_nxt = (state_nxt == S_ACTIVE) || (state_nxt == S_FILTER);
                ready_nxt     = (state_nxt == S_ACTIVE);
                filt_in_nxt   = (state_nxt != S_ASSERT);
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state            <= S_OFF;
            cnt              <= '0;
            vcchib_q         <= 1'b0;
            use_filt_q       <= 1'b0;
            ENABLE_VDDIO     <= 1'b0;
            ENABLE_H         <= 1'b0;
            EN_VDDIO_SIG_H   <= 1'b1;
            INP_SEL_H        <= 1'b0;
            DISABLE_PULLUP_H <= 1'b0;
            FILT_IN_H        <= 1'b1;
            SYS_RST_N        <= 1'b0;
            READY            <= 1'b0;
            GLITCH           <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            vcchib_q         <= vcchib_nxt;
            use_filt_q       <= use_filt_nxt;
            ENABLE_VDDIO     <= en_vddio_nxt;
            ENABLE_H         <= en_h_nxt;
            EN_VDDIO_SIG_H   <= en_sig_nxt;
            INP_SEL_H        <= inp_sel_nxt;
            DISABLE_PULLUP_H <= 1'b0;
            FILT_IN_H        <= filt_in_nxt;
            SYS_RST_N        <= sys_rst_n_nxt;
            READY            <= ready_nxt;
            GLITCH           <= glitch_nxt;
        end
    end

`ifdef SKY130_FD_IO_XRES_SEQ_GLITCH_CNT_EN
    // Survives power-good loss; only RESET_B clears the history.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B)                               GLITCH_CNT <= 8'h00;
        else if (glitch_nxt && GLITCH_CNT != 8'hFF) GLITCH_CNT <= GLITCH_CNT + 8'h01;
    end
`else
    assign GLITCH_CNT = 8'h00;
`endif

endmodule
